// File: rtl/ex_div_seq_pkg.sv
// Shared definitions for the EX-stage sequential divider.
package ex_div_seq_pkg;

  localparam int unsigned DivWidth = 32;
  localparam int unsigned DivCntW  = 6;

  // Divider sequencer states
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic RstEnable         = 1'b1;

  localparam logic [DivWidth-1:0] ZeroWord = '0;

  // Bit of the pipeline controller's stall vector driven by the EX stage
  localparam int unsigned StallIdxEx = 3;

endpackage

// File: rtl/ex_div_seq_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract.
module ex_div_seq_div_step
  import ex_div_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidth
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] dvd_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] dvd_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Partial remainder needs one extra bit before subtraction; MSB of trial is its sign
  always_comb begin
    shifted = {rem_i, dvd_i[WIDTH-1]};
    trial   = shifted - {1'b0, divisor_i};
    if (!trial[WIDTH]) begin
      rem_o = trial[WIDTH-1:0];
      dvd_o = {dvd_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      dvd_o = {dvd_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; returns {remainder, quotient}.
module ex_div_seq
  import ex_div_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidth,
  parameter int unsigned CNT_W = DivCntW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 stall_req_o
);

  div_state_e         state_q, state_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sgn_q, sgn_d;
  logic               neg1_q, neg1_d;
  logic               neg2_q, neg2_d;
  logic [2*WIDTH-1:0] result_d;
  logic               ready_d;

  logic [WIDTH-1:0]   step_rem, step_dvd;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  ex_div_seq_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .dvd_i     (dvd_q),
    .divisor_i (dsr_q),
    .rem_o     (step_rem),
    .dvd_o     (step_dvd)
  );

  // Pipeline must hold EX while an accepted request has no result yet
  assign stall_req_o = start_i & ~ready_o & ~annul_i;

  // Next-state, datapath and output computation
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    cnt_d    = cnt_q;
    sgn_d    = sgn_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    result_d = result_o;
    ready_d  = ready_o;

    mag1    = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    mag2    = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    quo_fix = (sgn_q && (neg1_q ^ neg2_q)) ? -step_dvd : step_dvd;
    rem_fix = (sgn_q && neg1_q) ? -step_rem : step_rem;

    case (state_q)
      DivFree: begin
        ready_d  = DivResultNotReady;
        result_d = '0;
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            state_d = DivOn;
            dvd_d   = mag1;
            dsr_d   = mag2;
            rem_d   = '0;
            cnt_d   = '0;
            sgn_d   = signed_div_i;
            neg1_d  = opdata1_i[WIDTH-1];
            neg2_d  = opdata2_i[WIDTH-1];
          end
        end
      end
      DivByZero: begin
        result_d = '0;
        if (annul_i) begin
          state_d = DivFree;
          ready_d = DivResultNotReady;
        end else begin
          state_d = DivEnd;
          ready_d = DivResultReady;
        end
      end
      DivOn: begin
        if (annul_i) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = '0;
        end else begin
          rem_d = step_rem;
          dvd_d = step_dvd;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d  = DivEnd;
            ready_d  = DivResultReady;
            result_d = {rem_fix, quo_fix};
          end
        end
      end
      DivEnd: begin
        if (annul_i || start_i == DivStop) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = '0;
        end
      end
      default: begin
        state_d  = DivFree;
        ready_d  = DivResultNotReady;
        result_d = '0;
      end
    endcase
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q  <= DivFree;
      rem_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      cnt_q    <= '0;
      sgn_q    <= 1'b0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      cnt_q    <= cnt_d;
      sgn_q    <= sgn_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      result_o <= result_d;
      ready_o  <= ready_d;
    end
  end

endmodule

// File: doc/ex_div_seq.md
Name: ex_div_seq

Overview:
Multi-cycle radix-2 restoring divider sequencer for the EX stage. It serves DIV/DIVU, one quotient bit per cycle. While busy it raises a stall request to the pipeline controller. It returns {remainder, quotient} for the HI/LO write path.

Parameters:
WIDTH, 32, operand width in bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset; synchronous, active-high
signed_div_i  input  1  1 = DIV (two's complement), 0 = DIVU
opdata1_i  input  WIDTH  dividend
opdata2_i  input  WIDTH  divisor
start_i  input  1  request; EX holds high until ready_o seen
annul_i  input  1  cancel in-flight op (branch flush/exception)
result_o  output  2*WIDTH  {remainder, quotient}; HI = remainder, LO = quotient
ready_o  output  1  result_o valid
stall_req_o  output  1  combinational: start_i & ~ready_o & ~annul_i

Behaviour:
- rst=1 at a clock edge: state=IDLE; result_o=0, ready_o=0, counter=0. Applies mid-operation too; the partial result is discarded.
- States:
  - IDLE
  - BYZERO
  - RUN
  - DONE
- IDLE:
  - start_i=1 & annul_i=0 & opdata2_i=0 -> BYZERO.
  - start_i=1 & annul_i=0 & opdata2_i≠0 -> RUN.
    - Latch magnitudes: if signed_div_i and operand[WIDTH-1] is set, take the two's complement; else take the operand as-is.
    - Latch signed_div_i and both operand sign bits.
    - Clear the partial remainder; counter=0.
  - Otherwise stay in IDLE; annul_i has priority over start_i.
- RUN, one step per cycle:
  - Shift {rem, dvd} left by 1.
  - trial = rem - divisor magnitude, WIDTH+1 bits.
  - If trial is non-negative: rem = trial and quotient LSB = 1; else quotient LSB = 0.
  - counter++.
  - After the step with counter = WIDTH-1 -> DONE.
    - Apply sign fix-up into result_o on this transition.
    - Quotient is negated iff signed and the operand signs differ.
    - Remainder is negated iff signed and the dividend was negative.
- BYZERO: one cycle, result_o={0,0} -> DONE. Divide-by-zero result is 0 by definition.
- DONE:
  - ready_o=1; result_o is held stable.
  - start_i=0 -> IDLE, with ready_o=0 and result_o=0 next cycle.
  - start_i=1 -> stay in DONE.
- annul_i=1 in RUN, BYZERO or DONE -> IDLE next cycle, result_o=0, ready_o=0. No HI/LO result is produced.
- Latency, with start accepted at edge 0:
  - Normal op: RUN occupies cycles 1..WIDTH; ready_o is high in cycle WIDTH+1 (cycle 33 at default).
  - Divide-by-zero: ready_o is high in cycle 2.
- Signed boundary: 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. The wrap is architecturally ignored; no overflow flag.
- Operand inputs are don't-care outside the IDLE accept cycle. Changes to them during RUN must not affect the result.
- Back-to-back: in DONE, start_i must drop for at least one cycle before the next operation is accepted.

Decomposition:
- Shared defines file gets:
  - state encodings: DivFree, DivByZero, DivOn, DivEnd
  - DivResultReady / DivResultNotReady
  - DivStart / DivStop
  - existing ZeroWord and RstEnable constants
- Stall-request bit index for the pipeline controller also goes in the shared defines.
- Optional sub-module div_step: combinational single iteration. Inputs are rem, dvd and divisor; outputs are next rem and next dvd.

Test Plan:
- Unsigned 100 / 7 (signed_div_i=0), start held -> ready_o in cycle 33; result_o={32'd2, 32'd14}; stall_req_o high during cycles 0..32.
- Signed -7 / 2 (0xFFFFFFF9, 0x2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; then drop start -> IDLE, ready_o=0, result_o=0.
- Divide-by-zero, 5 / 0 -> ready_o in cycle 2, result_o=0; no RUN state entered.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. Also unsigned 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0.
- annul_i pulsed in cycle 10 of RUN -> IDLE next cycle, ready_o never asserts. A new start of 9 / 3 is then accepted -> quotient 3, remainder 0, correct latency.
- rst asserted in cycle 15 of RUN -> all outputs 0 next cycle. With start_i still high after rst releases, the operation restarts from IDLE with full 33-cycle latency.
